// File: rtl/lift_call_queue_pkg.sv
// Shared definitions for the lift call queue: FSM states, floor-code type,
// floor-count and debounce defaults, and floor-code sanitising helper.
// Build option: LIFT_CALL_DEBOUNCE_EN enables the button debouncer.
package lift_pkg;

  localparam int MAX_FLOORS              = 7;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  typedef logic [2:0] floor_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    OFFER  = 2'd2,
    BUSY   = 2'd3
  } state_t;

  // Codes 0 and anything above the served range are treated as floor 1.
  function automatic floor_t sanitize_floor(input floor_t f, input int num_floors);
    if ((f != 3'd0) && (int'(f) <= num_floors)) begin
      return f;
    end else begin
      return 3'd1;
    end
  endfunction

endpackage

// File: rtl/lift_call_queue_if.sv
// Target handshake between the call queue (master) and the lift
// controller (slave): offered target, acceptance, arrival and car position.
// Build option: LIFT_CALL_DEBOUNCE_EN (no effect on this interface).
interface lift_call_queue_if;
  import lift_pkg::*;

  logic   req_valid;
  logic   req_ready;
  floor_t req_floor;
  logic   arrived;
  floor_t cur_floor;

  modport master (
    output req_valid,
    output req_floor,
    input  req_ready,
    input  arrived,
    input  cur_floor
  );

  modport slave (
    input  req_valid,
    input  req_floor,
    output req_ready,
    output arrived,
    output cur_floor
  );

endinterface

// File: rtl/lift_call_queue_debounce.sv
// Per-button front end: 2-flop synchronizer, optional stability debounce,
// and a registered one-cycle pulse on each accepted rising edge.
// Build option: LIFT_CALL_DEBOUNCE_EN enables the debounce counter; without
// it the edge detector is fed straight from the synchronizer.
module lift_debounce
  import lift_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  logic sync1_r;
  logic sync2_r;
  logic level_s;
  logic level_d_r;
  logic press_r;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

`ifdef LIFT_CALL_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_r;
  logic          stable_r;

  // Accept a new level only after it has differed from the stable one
  // for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r    <= {CW{1'b0}};
      stable_r <= 1'b0;
    end else if (sync2_r != stable_r) begin
      if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_r <= sync2_r;
        cnt_r    <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= {CW{1'b0}};
    end
  end

  assign level_s = stable_r;
`else
  // Debounce length has no effect in the bypass build.
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign level_s = sync2_r;
`endif

  // One pulse per rising edge of the accepted level, however long it is held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_d_r <= 1'b0;
      press_r   <= 1'b0;
    end else begin
      level_d_r <= level_s;
      press_r   <= level_s & ~level_d_r;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/lift_call_queue.sv
// Lift call queue: collects debounced floor-call presses into a pending
// mask and offers one target at a time to the lift controller using a
// SCAN (elevator) policy. The target is frozen from offer until arrival.
// Build option: LIFT_CALL_DEBOUNCE_EN enables the per-button debouncer.
module lift_call_queue
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS      = MAX_FLOORS,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] btn,
  lift_call_queue_if.master     bus,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up
);

  logic [NUM_FLOORS-1:0] press_s;
  logic [NUM_FLOORS-1:0] clear_s;
  logic [NUM_FLOORS-1:0] pending_r;

  state_t state_r;
  state_t state_nxt_s;

  floor_t cur_s;
  floor_t req_floor_r;
  floor_t target_s;
  floor_t up_floor_s;
  floor_t dn_floor_s;
  logic   req_valid_r;
  logic   dir_up_r;
  logic   target_dir_s;
  logic   at_hit_s;
  logic   up_hit_s;
  logic   dn_hit_s;

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_btn
    lift_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn[i]),
      .press(press_s[i])
    );
  end

  assign cur_s = sanitize_floor(bus.cur_floor, NUM_FLOORS);

  // Find a call at the car, the nearest call above and the nearest below.
  always_comb begin
    at_hit_s   = 1'b0;
    up_hit_s   = 1'b0;
    dn_hit_s   = 1'b0;
    up_floor_s = 3'd1;
    dn_floor_s = 3'd1;
    // Scanning downwards leaves the lowest floor above the car.
    for (int f = NUM_FLOORS; f >= 1; f--) begin
      up_hit_s   = up_hit_s | (pending_r[f-1] && (f > int'(cur_s)));
      up_floor_s = (pending_r[f-1] && (f > int'(cur_s))) ? floor_t'(f) : up_floor_s;
    end
    // Scanning upwards leaves the highest floor below the car.
    for (int f = 1; f <= NUM_FLOORS; f++) begin
      dn_hit_s   = dn_hit_s | (pending_r[f-1] && (f < int'(cur_s)));
      dn_floor_s = (pending_r[f-1] && (f < int'(cur_s))) ? floor_t'(f) : dn_floor_s;
      at_hit_s   = at_hit_s | (pending_r[f-1] && (f == int'(cur_s)));
    end
  end

  // SCAN choice: serve the car's floor, else keep sweeping, else reverse.
  always_comb begin
    target_s     = cur_s;
    target_dir_s = dir_up_r;
    if (at_hit_s) begin
      target_s     = cur_s;
      target_dir_s = dir_up_r;
    end else if (dir_up_r) begin
      if (up_hit_s) begin
        target_s = up_floor_s;
      end else begin
        target_s     = dn_floor_s;
        target_dir_s = 1'b0;
      end
    end else begin
      if (dn_hit_s) begin
        target_s = dn_floor_s;
      end else begin
        target_s     = up_floor_s;
        target_dir_s = 1'b1;
      end
    end
  end

  // Next-state logic; arrival only matters while a target is being served.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (|pending_r) begin
          state_nxt_s = SELECT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SELECT: begin
        state_nxt_s = OFFER;
      end
      OFFER: begin
        if (req_valid_r && bus.req_ready) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = OFFER;
        end
      end
      BUSY: begin
        if (bus.arrived) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Clear mask for the served floor on arrival.
  always_comb begin
    clear_s = {NUM_FLOORS{1'b0}};
    for (int f = 1; f <= NUM_FLOORS; f++) begin
      clear_s[f-1] = (state_r == BUSY) && bus.arrived && (req_floor_r == floor_t'(f));
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Pending mask, offer handshake, frozen target and sweep direction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_r   <= {NUM_FLOORS{1'b0}};
      req_valid_r <= 1'b0;
      req_floor_r <= 3'd1;
      dir_up_r    <= 1'b1;
    end else begin
      // A clear overrides a press of the same floor in the same cycle.
      pending_r   <= (pending_r | press_s) & ~clear_s;
      req_valid_r <= (state_nxt_s == OFFER);
      if (state_r == SELECT) begin
        req_floor_r <= target_s;
        dir_up_r    <= target_dir_s;
      end
    end
  end

  assign bus.req_valid = req_valid_r;
  assign bus.req_floor = req_floor_r;
  assign pending       = pending_r;
  assign dir_up        = dir_up_r;

endmodule

// File: tb/tb_lift_call_queue.sv
// Directed bench for lift_call_queue with DEBOUNCE_CYCLES = 4.
// Works with and without LIFT_CALL_DEBOUNCE_EN.
module tb_lift_call_queue;

  localparam int NF = 7;
`ifdef LIFT_CALL_DEBOUNCE_EN
  // btn rise -> pending set: 2 sync + 4 debounce + edge reg + pending reg.
  localparam int PRESS_LAT = 8;
`else
  // btn rise -> pending set: 2 sync + edge reg + pending reg.
  localparam int PRESS_LAT = 4;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NF-1:0] btn;
  logic [NF-1:0] pending;
  logic          dir_up;

  int checks = 0;
  int errors = 0;

  lift_call_queue_if bus_if ();

  lift_call_queue #(
    .NUM_FLOORS     (NF),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (btn),
    .bus    (bus_if),
    .pending(pending),
    .dir_up (dir_up)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pending(input logic [NF-1:0] mask, input string tag);
    int n;
    n = 0;
    while (((pending & mask) != mask) && (n < 40)) begin
      tick();
      n++;
    end
    check(tag, 32'(pending & mask), 32'(mask));
  endtask

  initial begin
    rst_n            = 1'b0;
    btn              = 7'b0;
    bus_if.req_ready = 1'b0;
    bus_if.arrived   = 1'b0;
    bus_if.cur_floor = 3'd1;
    repeat (3) tick();
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_valid", 32'(bus_if.req_valid), 32'h0);
    check("rst_floor", 32'(bus_if.req_floor), 32'h1);
    check("rst_dir", 32'(dir_up), 32'h1);
    rst_n = 1'b1;
    tick();

    // Arrival while idle is ignored.
    bus_if.arrived = 1'b1;
    tick();
    bus_if.arrived = 1'b0;
    check("idle_arr_pending", 32'(pending), 32'h0);
    tick();
    check("idle_arr_valid", 32'(bus_if.req_valid), 32'h0);

    // Held press of floor 5: set once, 2-cycle offer latency, arrival clears.
    bus_if.req_ready = 1'b1;
    btn = 7'b0010000;
    wait_pending(7'b0010000, "p5_set");
    check("p5_only", 32'(pending), 32'h10);
    check("p5_lat0", 32'(bus_if.req_valid), 32'h0);
    tick();
    check("p5_lat1", 32'(bus_if.req_valid), 32'h0);
    tick();
    check("p5_valid", 32'(bus_if.req_valid), 32'h1);
    check("p5_floor", 32'(bus_if.req_floor), 32'h5);
    tick();
    check("p5_busy", 32'(bus_if.req_valid), 32'h0);
    repeat (25) tick();
    check("p5_once", 32'(pending), 32'h10);
    bus_if.cur_floor = 3'd5;
    bus_if.arrived   = 1'b1;
    tick();
    bus_if.arrived = 1'b0;
    check("p5_clear", 32'(pending), 32'h0);
    repeat (10) tick();
    check("p5_hold_nodup", 32'(pending), 32'h0);
    check("p5_idle", 32'(bus_if.req_valid), 32'h0);
    btn = 7'b0;
    repeat (12) tick();

    // Two-cycle glitch on floor 3.
    bus_if.cur_floor = 3'd1;
    btn = 7'b0000100;
    tick();
    tick();
    btn = 7'b0;
    repeat (15) tick();
`ifdef LIFT_CALL_DEBOUNCE_EN
    check("glitch_reject", 32'(pending), 32'h0);
`else
    check("glitch_pass", 32'(pending), 32'h04);
`endif
    bus_if.arrived = 1'b1;
    tick();
    bus_if.arrived = 1'b0;
    check("glitch_clear", 32'(pending), 32'h0);
    check("glitch_dir", 32'(dir_up), 32'h1);
    repeat (5) tick();

    // SCAN: car at 4 sweeping up, calls at 2 and 6.
    bus_if.cur_floor = 3'd4;
    btn = 7'b0100010;
    wait_pending(7'b0100010, "scan_set");
    check("scan_pending", 32'(pending), 32'h22);
    tick();
    tick();
    check("scan_valid", 32'(bus_if.req_valid), 32'h1);
    check("scan_floor6", 32'(bus_if.req_floor), 32'h6);
    check("scan_dir_up", 32'(dir_up), 32'h1);
    tick();
    check("scan_busy", 32'(bus_if.req_valid), 32'h0);
    btn = 7'b0;
    bus_if.cur_floor = 3'd6;
    bus_if.arrived   = 1'b1;
    tick();
    bus_if.arrived   = 1'b0;
    bus_if.req_ready = 1'b0;
    check("scan_left2", 32'(pending), 32'h02);
    tick();
    tick();
    check("scan_valid2", 32'(bus_if.req_valid), 32'h1);
    check("scan_floor2", 32'(bus_if.req_floor), 32'h2);
    check("scan_dir_dn", 32'(dir_up), 32'h0);

    // Stalled offer: new nearer call must not change the target.
    btn = 7'b0000100;
    wait_pending(7'b0000100, "stall_set");
    repeat (4) tick();
    btn = 7'b0;
    repeat (10) tick();
    check("stall_valid", 32'(bus_if.req_valid), 32'h1);
    check("stall_floor", 32'(bus_if.req_floor), 32'h2);
    check("stall_pending", 32'(pending), 32'h06);
    bus_if.req_ready = 1'b1;
    tick();
    check("stall_busy", 32'(bus_if.req_valid), 32'h0);
    bus_if.cur_floor = 3'd2;
    bus_if.arrived   = 1'b1;
    tick();
    bus_if.arrived = 1'b0;
    check("stall_left3", 32'(pending), 32'h04);
    tick();
    tick();
    check("rev_valid", 32'(bus_if.req_valid), 32'h1);
    check("rev_floor3", 32'(bus_if.req_floor), 32'h3);
    check("rev_dir_up", 32'(dir_up), 32'h1);
    tick();
    check("rev_busy", 32'(bus_if.req_valid), 32'h0);

    // Fresh press of floor 3 lands on the same edge as its clear.
    bus_if.cur_floor = 3'd3;
    btn = 7'b0000100;
    repeat (PRESS_LAT - 1) tick();
    bus_if.arrived = 1'b1;
    tick();
    bus_if.arrived = 1'b0;
    check("same_cycle_clear", 32'(pending), 32'h0);
    repeat (5) tick();
    check("same_cycle_stay", 32'(pending), 32'h0);
    check("same_cycle_idle", 32'(bus_if.req_valid), 32'h0);
    btn = 7'b0;
    repeat (12) tick();

    // Reset while busy with calls at 1, 3, 5, 7.
    bus_if.cur_floor = 3'd1;
    btn = 7'b1010101;
    wait_pending(7'b1010101, "mrst_set");
    tick();
    tick();
    check("mrst_valid", 32'(bus_if.req_valid), 32'h1);
    check("mrst_floor1", 32'(bus_if.req_floor), 32'h1);
    tick();
    btn = 7'b0;
    check("mrst_busy", 32'(bus_if.req_valid), 32'h0);
    check("mrst_pending", 32'(pending), 32'h55);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_pend0", 32'(pending), 32'h0);
    check("mrst_valid0", 32'(bus_if.req_valid), 32'h0);
    check("mrst_dir", 32'(dir_up), 32'h1);
    check("mrst_floor", 32'(bus_if.req_floor), 32'h1);
    repeat (5) tick();
    check("mrst_idle_valid", 32'(bus_if.req_valid), 32'h0);
    check("mrst_idle_pend", 32'(pending), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
